// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder
// Turns four captured active-low seven-segment digit patterns (MM:SS) back
// into binary minutes and seconds. One digit is decoded per clock by a small
// state machine; results come out through a start/busy/valid handshake with
// an error flag for illegal patterns or out-of-range times.

module sevenseg_decoder (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       start,
   input  logic [6:0] HexM_2,
   input  logic [6:0] HexM_1,
   input  logic [6:0] HexS_2,
   input  logic [6:0] HexS_1,
   output logic [1:0] Qm,
   output logic [5:0] Qs,
   output logic       busy,
   output logic       valid,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DEC_S1 = 3'd1,
      DEC_S2 = 3'd2,
      DEC_M1 = 3'd3,
      DEC_M2 = 3'd4,
      CHECK  = 3'd5
   } state_t;

   state_t state;
   state_t state_next;

   logic [6:0] hex_m2_q;
   logic [6:0] hex_m1_q;
   logic [6:0] hex_s2_q;
   logic [6:0] hex_s1_q;

   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       illegal_q;

   logic [6:0] cur_pattern;
   logic [3:0] dec_digit;
   logic       dec_illegal;

   logic       range_ok;
   logic [5:0] sec_tens6;
   logic [5:0] qs_calc;

   // State register: the decode sequence restarts from IDLE on reset
   always_ff @(posedge CLK) begin
      if (Reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic: accept a request only from IDLE, then walk the digits
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = DEC_S1;
         DEC_S1:  state_next = DEC_S2;
         DEC_S2:  state_next = DEC_M1;
         DEC_M1:  state_next = DEC_M2;
         DEC_M2:  state_next = CHECK;
         CHECK:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: busy covers every non-idle state
   always_comb begin
      busy = (state != IDLE);
   end

   // Select the latched pattern belonging to the digit decoded this cycle
   always_comb begin
      cur_pattern = 7'h7F;
      case (state)
         DEC_S1:  cur_pattern = hex_s1_q;
         DEC_S2:  cur_pattern = hex_s2_q;
         DEC_M1:  cur_pattern = hex_m1_q;
         DEC_M2:  cur_pattern = hex_m2_q;
         default: cur_pattern = 7'h7F;
      endcase
   end

   // Pattern-to-BCD lookup; anything not in the table (blank included) is illegal
   always_comb begin
      dec_digit   = 4'd0;
      dec_illegal = 1'b0;
      case (cur_pattern)
         7'h40:   dec_digit = 4'd0;
         7'h79:   dec_digit = 4'd1;
         7'h24:   dec_digit = 4'd2;
         7'h30:   dec_digit = 4'd3;
         7'h19:   dec_digit = 4'd4;
         7'h12:   dec_digit = 4'd5;
         7'h02:   dec_digit = 4'd6;
         7'h78:   dec_digit = 4'd7;
         7'h00:   dec_digit = 4'd8;
         7'h10:   dec_digit = 4'd9;
         default: begin
            dec_digit   = 4'd0;
            dec_illegal = 1'b1;
         end
      endcase
   end

   // Capture inputs on an accepted request and fill one digit register per decode state
   always_ff @(posedge CLK) begin
      if (Reset) begin
         hex_m2_q  <= 7'd0;
         hex_m1_q  <= 7'd0;
         hex_s2_q  <= 7'd0;
         hex_s1_q  <= 7'd0;
         min_tens  <= 4'd0;
         min_ones  <= 4'd0;
         sec_tens  <= 4'd0;
         sec_ones  <= 4'd0;
         illegal_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               illegal_q <= 1'b0;
               if (start) begin
                  hex_m2_q <= HexM_2;
                  hex_m1_q <= HexM_1;
                  hex_s2_q <= HexS_2;
                  hex_s1_q <= HexS_1;
               end
            end
            DEC_S1: begin
               sec_ones <= dec_digit;
               if (dec_illegal) illegal_q <= 1'b1;
            end
            DEC_S2: begin
               sec_tens <= dec_digit;
               if (dec_illegal) illegal_q <= 1'b1;
            end
            DEC_M1: begin
               min_ones <= dec_digit;
               if (dec_illegal) illegal_q <= 1'b1;
            end
            DEC_M2: begin
               min_tens <= dec_digit;
               if (dec_illegal) illegal_q <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Range check and binary seconds; tens*10 is built from shifts to avoid a multiplier
   always_comb begin
      range_ok  = (sec_tens <= 4'd5) && (min_tens == 4'd0) && (min_ones <= 4'd3);
      sec_tens6 = {2'b00, sec_tens};
      qs_calc   = (sec_tens6 << 3) + (sec_tens6 << 1) + {2'b00, sec_ones};
   end

   // Result registers: only CHECK updates them, so they hold between requests
   always_ff @(posedge CLK) begin
      if (Reset) begin
         Qm    <= 2'd0;
         Qs    <= 6'd0;
         err   <= 1'b0;
         valid <= 1'b0;
      end else begin
         valid <= (state == CHECK);
         if (state == CHECK) begin
            if (range_ok && !illegal_q) begin
               Qm  <= min_ones[1:0];
               Qs  <= qs_calc;
               err <= 1'b0;
            end else begin
               Qm  <= 2'd0;
               Qs  <= 6'd0;
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_decoder.sv
// tb_sevenseg_decoder
// Directed-vector bench for sevenseg_decoder with hand-computed results.

module tb_sevenseg_decoder;

   logic       CLK;
   logic       Reset;
   logic       start;
   logic [6:0] HexM_2;
   logic [6:0] HexM_1;
   logic [6:0] HexS_2;
   logic [6:0] HexS_1;
   logic [1:0] Qm;
   logic [5:0] Qs;
   logic       busy;
   logic       valid;
   logic       err;

   int assertCount = 0;
   int failCount   = 0;

   sevenseg_decoder dut (
      .CLK    (CLK),
      .Reset  (Reset),
      .start  (start),
      .HexM_2 (HexM_2),
      .HexM_1 (HexM_1),
      .HexS_2 (HexS_2),
      .HexS_1 (HexS_1),
      .Qm     (Qm),
      .Qs     (Qs),
      .busy   (busy),
      .valid  (valid),
      .err    (err)
   );

   // 10 ns clock
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Hand-written segment table (active low, bit0 = a)
   function automatic logic [6:0] pat(input int d);
      case (d)
         0:       return 7'h40;
         1:       return 7'h79;
         2:       return 7'h24;
         3:       return 7'h30;
         4:       return 7'h19;
         5:       return 7'h12;
         6:       return 7'h02;
         7:       return 7'h78;
         8:       return 7'h00;
         9:       return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic setHex(input logic [6:0] m2, input logic [6:0] m1,
                         input logic [6:0] s2, input logic [6:0] s1);
      HexM_2 = m2;
      HexM_1 = m1;
      HexS_2 = s2;
      HexS_1 = s1;
   endtask

   // One full request: pulse start, check busy window, valid timing and results
   task automatic applyStimulus(input string name,
                                input logic [6:0] m2, input logic [6:0] m1,
                                input logic [6:0] s2, input logic [6:0] s1,
                                input int expQm, input int expQs, input int expErr);
      setHex(m2, m1, s2, s1);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput({name, ".busyN"}, busy, 1);
      checkOutput({name, ".validN"}, valid, 0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         checkOutput({name, ".busy"}, busy, 1);
         checkOutput({name, ".valid"}, valid, 0);
      end
      tick();
      checkOutput({name, ".valid5"}, valid, 1);
      checkOutput({name, ".busy5"}, busy, 0);
      checkOutput({name, ".Qm"}, Qm, expQm);
      checkOutput({name, ".Qs"}, Qs, expQs);
      checkOutput({name, ".err"}, err, expErr);
      tick();
      checkOutput({name, ".validOff"}, valid, 0);
      checkOutput({name, ".QsHold"}, Qs, expQs);
      checkOutput({name, ".errHold"}, err, expErr);
   endtask

   initial begin
      int validCount;
      int validEdge;
      int lastEdge;
      int gapBad;

      Reset = 1'b1;
      start = 1'b1;
      setHex(pat(0), pat(2), pat(4), pat(9));

      // Reset held two cycles with start high
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("rst.Qm", Qm, 0);
         checkOutput("rst.Qs", Qs, 0);
         checkOutput("rst.err", err, 0);
         checkOutput("rst.valid", valid, 0);
         checkOutput("rst.busy", busy, 0);
      end
      Reset = 1'b0;
      start = 1'b0;
      tick();
      checkOutput("rstRel.busy", busy, 0);
      checkOutput("rstRel.valid", valid, 0);
      checkOutput("rstRel.Qs", Qs, 0);

      // Legal decodes and range boundaries
      applyStimulus("t0249", pat(0), pat(2), pat(4), pat(9), 2, 49, 0);
      applyStimulus("t0359", pat(0), pat(3), pat(5), pat(9), 3, 59, 0);
      applyStimulus("t0000", pat(0), pat(0), pat(0), pat(0), 0, 0, 0);
      applyStimulus("t0237", pat(0), pat(2), pat(3), pat(7), 2, 37, 0);
      applyStimulus("t0158", pat(0), pat(1), pat(5), pat(8), 1, 58, 0);
      applyStimulus("t0400", pat(0), pat(4), pat(0), pat(0), 0, 0, 1);
      applyStimulus("t0060", pat(0), pat(0), pat(6), pat(0), 0, 0, 1);
      applyStimulus("t1000", pat(1), pat(0), pat(0), pat(0), 0, 0, 1);

      // Illegal (blank) seconds digit, then a legal request clears err
      applyStimulus("blank", pat(0), pat(1), pat(2), 7'h7F, 0, 0, 1);
      applyStimulus("t0123", pat(0), pat(1), pat(2), pat(3), 1, 23, 0);

      // Start at cycles 0 and 2, inputs changed at cycle 1
      setHex(pat(0), pat(1), pat(1), pat(5));
      start = 1'b1;
      tick();
      start = 1'b0;
      setHex(pat(0), pat(2), pat(3), pat(7));
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      validCount = 0;
      validEdge  = -1;
      for (int e = 3; e <= 12; e++) begin
         tick();
         if (valid) begin
            validCount++;
            validEdge = e;
            checkOutput("ign.Qm", Qm, 1);
            checkOutput("ign.Qs", Qs, 15);
            checkOutput("ign.err", err, 0);
         end
      end
      checkOutput("ign.validCount", validCount, 1);
      checkOutput("ign.validEdge", validEdge, 5);

      // Reset at cycle 3 of a decode aborts it
      setHex(pat(0), pat(2), pat(4), pat(9));
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checkOutput("abort.busy", busy, 0);
      checkOutput("abort.Qm", Qm, 0);
      checkOutput("abort.Qs", Qs, 0);
      checkOutput("abort.err", err, 0);
      validCount = 0;
      for (int e = 0; e < 8; e++) begin
         tick();
         if (valid) validCount++;
      end
      checkOutput("abort.validCount", validCount, 0);
      checkOutput("abort.QsAfter", Qs, 0);

      // Start held high: one valid every 6 cycles
      setHex(pat(0), pat(3), pat(5), pat(9));
      start = 1'b1;
      tick();
      validCount = 0;
      lastEdge   = -1;
      gapBad     = 0;
      validEdge  = -1;
      for (int e = 1; e <= 19; e++) begin
         tick();
         if (valid) begin
            validCount++;
            if (validEdge < 0) validEdge = e;
            if (lastEdge >= 0 && (e - lastEdge) != 6) gapBad++;
            lastEdge = e;
            checkOutput("cont.Qs", Qs, 59);
         end
      end
      start = 1'b0;
      checkOutput("cont.validCount", validCount, 3);
      checkOutput("cont.firstEdge", validEdge, 5);
      checkOutput("cont.gapBad", gapBad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
